// File: rtl/sent_tx_pulse_gen.sv
`timescale 1ns/1ps
// sent_tx_pulse_gen
// -----------------
// SENT (SAE J2716) transmit pulse generator. Accepts one frame per
// frame_valid/frame_ready handshake and serialises it on data_pulse as a
// sequence of pulses:
//   SYNC -> STATUS -> DATA x N -> CRC -> [PAUSE] -> (next SYNC | TERM)
// Every pulse starts with a falling edge, stays low for LOW_TICKS ticks and
// is high for the rest of its length. A tick is (tick_div + 1) clocks.
//
// Ports
//   clk_tx        transmit clock, all logic on its rising edge
//   reset_tx      synchronous, active-high reset
//   tick_div      clocks per tick minus 1 (latched at acceptance)
//   frame_valid   frame request
//   frame_ready   high in IDLE or on the last clock of a frame
//   status_nb     status/communication nibble (latched at acceptance)
//   data_fast     data nibbles, nibble 1 at [23:20] (latched at acceptance)
//   nibble_count  number of data nibbles 1..6; 0 and 7 mean 6
//   pause_en      append a pause pulse after the CRC pulse
//   pause_ticks   pause pulse length in ticks; values below 12 mean 12
//   data_pulse    SENT line, idle high
//   busy          high whenever a frame or terminating pulse is active
//   frame_done    one-cycle pulse on the last clock of the frame
//   crc_out       CRC of the frame being sent
module sent_tx_pulse_gen #(
  parameter int unsigned LOW_TICKS  = 5,
  parameter int unsigned SYNC_TICKS = 56
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic [10:0] tick_div,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [3:0]  status_nb,
  input  logic [23:0] data_fast,
  input  logic [2:0]  nibble_count,
  input  logic        pause_en,
  input  logic [11:0] pause_ticks,
  output logic        data_pulse,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  crc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_STATUS,
    S_DATA,
    S_CRC,
    S_PAUSE,
    S_TERM
  } state_t;

  localparam logic [11:0] LOW_LEN  = 12'(LOW_TICKS);
  localparam logic [11:0] SYNC_LEN = 12'(SYNC_TICKS);
  localparam logic [11:0] MIN_LEN  = 12'd12;

  state_t      state_q,      state_d;
  logic [10:0] div_q,        div_d;
  logic [10:0] cnt_q,        cnt_d;
  logic [11:0] ptick_q,      ptick_d;
  logic [3:0]  status_q,     status_d;
  logic [23:0] data_q,       data_d;
  logic [2:0]  nib_left_q,   nib_left_d;
  logic        pause_en_q,   pause_en_d;
  logic [11:0] pause_len_q,  pause_len_d;
  logic [3:0]  crc_q,        crc_d;
  logic        data_pulse_q, data_pulse_d;
  logic        init_q;

  logic        tick_en;
  logic        last_tick;
  logic        frame_end;
  logic        accept;
  logic [11:0] pulse_len;
  logic [2:0]  eff_count;

  // J2716 4-bit CRC table (seed 5, polynomial x^4+x^3+x^2+1)
  function automatic logic [3:0] crc_lookup(input logic [3:0] c);
    logic [3:0] r;
    case (c)
      4'd0:    r = 4'd0;
      4'd1:    r = 4'd13;
      4'd2:    r = 4'd7;
      4'd3:    r = 4'd10;
      4'd4:    r = 4'd14;
      4'd5:    r = 4'd3;
      4'd6:    r = 4'd9;
      4'd7:    r = 4'd4;
      4'd8:    r = 4'd1;
      4'd9:    r = 4'd12;
      4'd10:   r = 4'd6;
      4'd11:   r = 4'd11;
      4'd12:   r = 4'd15;
      4'd13:   r = 4'd2;
      4'd14:   r = 4'd8;
      default: r = 4'd5;
    endcase
    return r;
  endfunction

  // CRC over the first 'count' data nibbles (status excluded), followed by
  // the augmentation step. Computed in one go at acceptance so crc_out is
  // valid on the very next cycle.
  function automatic logic [3:0] crc_calc(input logic [23:0] nibs,
                                          input logic [2:0]  count);
    logic [3:0]  c;
    logic [23:0] sh;
    c  = 4'b0101;
    sh = nibs;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < count) begin
        c = crc_lookup(c) ^ sh[23:20];
      end
      sh = {sh[19:0], 4'd0};
    end
    return crc_lookup(c);
  endfunction

  assign eff_count = (nibble_count == 3'd0 || nibble_count == 3'd7) ? 3'd6 : nibble_count;

  // Length in ticks of the pulse currently being sent
  always_comb begin
    pulse_len = LOW_LEN;
    unique case (state_q)
      S_SYNC:   pulse_len = SYNC_LEN;
      S_STATUS: pulse_len = MIN_LEN + {8'd0, status_q};
      S_DATA:   pulse_len = MIN_LEN + {8'd0, data_q[23:20]};
      S_CRC:    pulse_len = MIN_LEN + {8'd0, crc_q};
      S_PAUSE:  pulse_len = pause_len_q;
      default:  pulse_len = LOW_LEN;
    endcase
  end

  assign tick_en   = (cnt_q == div_q);
  assign last_tick = tick_en && (ptick_q == pulse_len - 12'd1);

  // The frame ends on the last clock of CRC, or of PAUSE when enabled; only
  // that single clock may accept the next frame so back-to-back frames get
  // no extra or shortened ticks.
  assign frame_end   = last_tick &&
                       ((state_q == S_CRC && !pause_en_q) || state_q == S_PAUSE);
  assign frame_ready = init_q && (state_q == S_IDLE || frame_end);
  assign accept      = frame_valid && frame_ready;

  assign frame_done = frame_end;
  assign busy       = (state_q != S_IDLE);
  assign data_pulse = data_pulse_q;
  assign crc_out    = crc_q;

  // Next-state: tick divider, per-pulse tick counter, pulse sequencing and
  // frame latching. The line level is derived from the next state so that
  // data_pulse is a clean register output.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    ptick_d     = ptick_q;
    status_d    = status_q;
    data_d      = data_q;
    nib_left_d  = nib_left_q;
    pause_en_d  = pause_en_q;
    pause_len_d = pause_len_q;
    crc_d       = crc_q;

    if (state_q != S_IDLE) begin
      cnt_d = tick_en ? 11'd0 : cnt_q + 11'd1;
      if (tick_en) begin
        ptick_d = ptick_q + 12'd1;
      end
    end

    if (last_tick) begin
      ptick_d = 12'd0;
      unique case (state_q)
        S_SYNC:   state_d = S_STATUS;
        S_STATUS: state_d = S_DATA;
        S_DATA: begin
          data_d     = {data_q[19:0], 4'd0};
          nib_left_d = nib_left_q - 3'd1;
          if (nib_left_q == 3'd1) begin
            state_d = S_CRC;
          end
        end
        S_CRC:    state_d = pause_en_q ? S_PAUSE : S_TERM;
        S_PAUSE:  state_d = S_TERM;
        S_TERM:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    // Acceptance overrides the frame-end transition to TERM
    if (accept) begin
      state_d     = S_SYNC;
      cnt_d       = 11'd0;
      ptick_d     = 12'd0;
      div_d       = tick_div;
      status_d    = status_nb;
      data_d      = data_fast;
      nib_left_d  = eff_count;
      pause_en_d  = pause_en;
      pause_len_d = (pause_ticks < MIN_LEN) ? MIN_LEN : pause_ticks;
      crc_d       = crc_calc(data_fast, eff_count);
    end

    data_pulse_d = (state_d == S_IDLE) || (ptick_d >= LOW_LEN);
  end

  // State registers; reset aborts any frame and returns the line high
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q      <= S_IDLE;
      div_q        <= 11'd0;
      cnt_q        <= 11'd0;
      ptick_q      <= 12'd0;
      status_q     <= 4'd0;
      data_q       <= 24'd0;
      nib_left_q   <= 3'd0;
      pause_en_q   <= 1'b0;
      pause_len_q  <= 12'd0;
      crc_q        <= 4'd0;
      data_pulse_q <= 1'b1;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      ptick_q      <= ptick_d;
      status_q     <= status_d;
      data_q       <= data_d;
      nib_left_q   <= nib_left_d;
      pause_en_q   <= pause_en_d;
      pause_len_q  <= pause_len_d;
      crc_q        <= crc_d;
      data_pulse_q <= data_pulse_d;
      init_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
`timescale 1ns/1ps
// tb_sent_tx_pulse_gen
// --------------------
// Testbench for sent_tx_pulse_gen. Each accepted frame pushes the pulse
// train it should produce (fall-to-fall period and low time, in clocks) and
// its CRC into queues; an independent monitor measures the SENT line and
// pops/compares as pulses complete and as frame_done fires.
module tb_sent_tx_pulse_gen;

  localparam int LOW_TICKS  = 5;
  localparam int SYNC_TICKS = 56;

  logic        clk_tx = 1'b0;
  logic        reset_tx = 1'b1;
  logic [10:0] tick_div = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [3:0]  status_nb = '0;
  logic [23:0] data_fast = '0;
  logic [2:0]  nibble_count = '0;
  logic        pause_en = 1'b0;
  logic [11:0] pause_ticks = '0;
  logic        data_pulse;
  logic        busy;
  logic        frame_done;
  logic [3:0]  crc_out;

  typedef struct {
    int kind;
    int period;
    int low;
  } pulse_t;

  pulse_t pulse_q[$];
  int     crc_q[$];
  int     checks = 0;
  int     failures = 0;

  sent_tx_pulse_gen #(
    .LOW_TICKS (LOW_TICKS),
    .SYNC_TICKS(SYNC_TICKS)
  ) dut (
    .clk_tx      (clk_tx),
    .reset_tx    (reset_tx),
    .tick_div    (tick_div),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .status_nb   (status_nb),
    .data_fast   (data_fast),
    .nibble_count(nibble_count),
    .pause_en    (pause_en),
    .pause_ticks (pause_ticks),
    .data_pulse  (data_pulse),
    .busy        (busy),
    .frame_done  (frame_done),
    .crc_out     (crc_out)
  );

  always #5 clk_tx = ~clk_tx;

  // Reference CRC from the J2716 table description
  function automatic int crcModel(input int nibs[$]);
    int t[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};
    int c = 5;
    foreach (nibs[i]) c = t[c] ^ nibs[i];
    return t[c];
  endfunction

  function automatic string kindName(input int k);
    case (k)
      0:       return "sync";
      1:       return "status";
      2:       return "data";
      3:       return "crc";
      4:       return "pause";
      default: return "term";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic comparePulse(input int period, input int low);
    pulse_t e;
    if (pulse_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_pulse actual period=%0d low=%0d required=none", period, low);
    end else begin
      e = pulse_q.pop_front();
      checkOutput({kindName(e.kind), "_period"}, period, e.period);
      checkOutput({kindName(e.kind), "_low"}, low, e.low);
    end
  endtask

  // Reset the DUT and check the reset state plus the frame_ready release
  task automatic doReset();
    reset_tx    = 1'b1;
    frame_valid = 1'b0;
    @(posedge clk_tx); #1;
    checkOutput("rst_data_pulse", int'(data_pulse), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_frame_ready", int'(frame_ready), 0);
    checkOutput("rst_frame_done", int'(frame_done), 0);
    checkOutput("rst_crc_out", int'(crc_out), 0);
    repeat (2) @(posedge clk_tx);
    #1;
    reset_tx = 1'b0;
    @(negedge clk_tx);
    checkOutput("ready_before_first_clk", int'(frame_ready), 0);
    @(negedge clk_tx);
    checkOutput("ready_after_first_clk", int'(frame_ready), 1);
  endtask

  // Present one frame, wait for its acceptance and queue the expected
  // pulse train. b2b keeps frame_valid high so the next call is accepted
  // at this frame's end; abort_clks > 0 resets the DUT that many clocks
  // after acceptance.
  task automatic applyStimulus(input int div, input int st, input logic [23:0] data,
                               input int nc, input bit pen, input int pt,
                               input bit b2b, input int abort_clks);
    int          n;
    int          base;
    int          crc;
    int          nibs[$];
    logic [23:0] sh;
    bit          got;
    @(posedge clk_tx); #1;
    tick_div     = 11'(div);
    status_nb    = 4'(st);
    data_fast    = data;
    nibble_count = 3'(nc);
    pause_en     = pen;
    pause_ticks  = 12'(pt);
    frame_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      @(negedge clk_tx);
      if (frame_ready) got = 1'b1;
    end
    if (!got) begin
      failNow("frame_accept");
      return;
    end
    @(posedge clk_tx); #1;
    n    = (nc == 0 || nc == 7) ? 6 : nc;
    base = div + 1;
    sh   = data;
    for (int i = 0; i < n; i++) begin
      nibs.push_back(int'(sh[23:20]));
      sh = sh << 4;
    end
    crc = crcModel(nibs);
    pulse_q.push_back('{0, SYNC_TICKS * base, LOW_TICKS * base});
    pulse_q.push_back('{1, (12 + st) * base, LOW_TICKS * base});
    foreach (nibs[i]) pulse_q.push_back('{2, (12 + nibs[i]) * base, LOW_TICKS * base});
    pulse_q.push_back('{3, (12 + crc) * base, LOW_TICKS * base});
    if (pen) pulse_q.push_back('{4, ((pt < 12) ? 12 : pt) * base, LOW_TICKS * base});
    if (!b2b) pulse_q.push_back('{5, LOW_TICKS * base, LOW_TICKS * base});
    crc_q.push_back(crc);
    if (abort_clks > 0) begin
      frame_valid = 1'b0;
      repeat (abort_clks) @(posedge clk_tx);
      #1;
      pulse_q.delete();
      crc_q.delete();
      doReset();
      return;
    end
    if (!b2b) begin
      // Inputs may change freely once the frame is accepted
      frame_valid  = 1'b0;
      tick_div     = 11'($urandom_range(0, 2047));
      status_nb    = 4'($urandom);
      data_fast    = 24'($urandom);
      nibble_count = 3'($urandom);
      pause_en     = 1'($urandom);
      pause_ticks  = 12'($urandom);
      got = 1'b0;
      for (int i = 0; i < 30000 && !got; i++) begin
        @(negedge clk_tx);
        if (!busy) got = 1'b1;
      end
      if (!got) failNow("frame_finish");
    end
  endtask

  // Monitor: measure the SENT line fall-to-fall; a pulse still open when
  // busy drops is the terminating pulse. CRC is checked at frame_done.
  initial begin
    int cyc = 0;
    int fall_t = 0;
    int rise_t = 0;
    bit open = 1'b0;
    logic dp_prev = 1'b1;
    logic busy_prev = 1'b0;
    int exp_crc;
    forever begin
      @(negedge clk_tx);
      cyc++;
      if (reset_tx) begin
        open = 1'b0;
      end else begin
        if (dp_prev && !data_pulse) begin
          if (open) comparePulse(cyc - fall_t, rise_t - fall_t);
          open   = 1'b1;
          fall_t = cyc;
        end
        if (!dp_prev && data_pulse) rise_t = cyc;
        if (busy_prev && !busy && open) begin
          comparePulse(cyc - fall_t, rise_t - fall_t);
          open = 1'b0;
        end
        if (frame_done) begin
          if (crc_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_frame_done actual crc=%0d required=none", crc_out);
          end else begin
            exp_crc = crc_q.pop_front();
            checkOutput("crc_at_frame_done", int'(crc_out), exp_crc);
          end
        end
      end
      dp_prev   = data_pulse;
      busy_prev = busy;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  st;
    bit  b2b;
    doReset();

    // All-zero frame, 3 clocks per tick: CRC 5, 168-clock sync, 36-clock nibbles
    applyStimulus(2, 0, 24'h000000, 6, 1'b0, 0, 1'b0, 0);
    checkOutput("crc_zero_frame", int'(crc_out), 5);

    // One tick per clock, all-F data
    applyStimulus(0, int'($urandom_range(0, 15)), 24'hFFFFFF, 6, 1'b0, 0, 1'b0, 0);

    // Back-to-back frames with a 100-tick pause
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, int'($urandom_range(0, 15)), 24'($urandom), 6, 1'b1, 100, (i != 2), 0);
    end

    // Short and wrap-around nibble counts
    applyStimulus(0, 5, 24'($urandom), 3, 1'b0, 0, 1'b0, 0);
    applyStimulus(1, 9, 24'($urandom), 0, 1'b0, 0, 1'b0, 0);

    // Pause shorter than the minimum
    applyStimulus(0, 2, 24'($urandom), 2, 1'b1, 5, 1'b0, 0);

    // Reset during the first data nibble, then a clean frame
    st = int'($urandom_range(0, 15));
    applyStimulus(1, st, 24'($urandom), 6, 1'b0, 0, 1'b0, (SYNC_TICKS + 12 + st + 2) * 2);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_data_pulse", int'(data_pulse), 1);
    applyStimulus(0, 7, 24'h123456, 7, 1'b1, 20, 1'b0, 0);

    // Randomised frames, some chained back-to-back
    for (int i = 0; i < 12; i++) begin
      b2b = (i != 11) && ($urandom_range(0, 1) == 1);
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 24'($urandom),
                    int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 140)), b2b, 0);
    end

    repeat (10) @(posedge clk_tx);
    #1;
    checkOutput("pulses_left_in_queue", pulse_q.size(), 0);
    checkOutput("crcs_left_in_queue", crc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sent_tx_pulse_gen.md
SENT_TX_PULSE_GEN -- requirements
Module: sent_tx_pulse_gen

Interface
REQ-001 Parameter LOW_TICKS, 5, low-phase length of every SENT pulse in ticks.
REQ-002 Parameter SYNC_TICKS, 56, total sync/calibration pulse length in ticks.
REQ-003 clk_tx  in  1  transmit clock, single clock domain, all logic on rising edge.
REQ-004 reset_tx  in  1  reset, synchronous and active-high.
REQ-005 tick_div  in  11  clock cycles per tick minus 1, sampled at frame acceptance.
REQ-006 frame_valid  in  1  frame request; the frame is accepted when frame_valid and frame_ready are both high on the same edge.
REQ-007 frame_ready  out  1  high only in IDLE or on the final tick of CRC/PAUSE.
REQ-008 status_nb  in  4  status/communication nibble, sampled at acceptance.
REQ-009 data_fast  in  24  data nibbles, nibble 1 at [23:20], sampled at acceptance.
REQ-010 nibble_count  in  3  number of data nibbles 1..6; values 0 and 7 are treated as 6.
REQ-011 pause_en  in  1  append a pause pulse after CRC.
REQ-012 pause_ticks  in  12  total pause pulse length in ticks; values below 12 are treated as 12.
REQ-013 data_pulse  out  1  SENT line; idle high.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 frame_done  out  1  one-cycle pulse on the last clock of the CRC pulse, or of the PAUSE pulse when pause_en=1.
REQ-016 crc_out  out  4  CRC of the frame being sent, valid from one cycle after acceptance until the next acceptance.

Function
REQ-017 The tick counter counts 0..tick_div_latched; tick_en is asserted on the wrap cycle; the counter is reset to 0 on acceptance.
REQ-018 States: IDLE, SYNC, STATUS, DATA, CRC, PAUSE, TERM.
REQ-019 Every pulse begins with a falling edge, holds data_pulse=0 for LOW_TICKS ticks, and holds data_pulse=1 for the rest of its length.
REQ-020 Pulse lengths: SYNC = SYNC_TICKS; STATUS, DATA and CRC = 12 + nibble value; PAUSE = pause_ticks.
REQ-021 On acceptance in IDLE, the first falling edge of data_pulse occurs on the next clock, and the FSM enters SYNC.
REQ-022 Sequence: SYNC -> STATUS -> DATA (nibble_count nibbles, nibble 1 first) -> CRC -> PAUSE (if pause_en) -> frame end.
REQ-023 At frame end with frame_valid=1, the frame is accepted back-to-back and SYNC starts on the next tick with no extra ticks.
REQ-024 At frame end with frame_valid=0, the FSM enters TERM, drives LOW_TICKS low ticks to mark the end of the last nibble, drives high, and returns to IDLE.
REQ-025 CRC is SAE J2716 recommended 4-bit CRC over data nibbles only (status excluded): seed 4'b0101, polynomial x^4+x^3+x^2+1.
REQ-026 Table T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}; per nibble c = n ^ T[c]; then a final augmentation c = T[c].
REQ-027 The CRC may be computed sequentially; it SHALL be complete before the CRC state begins.
REQ-028 frame_valid while busy, other than at a frame end, is ignored; frame_ready stays low.
REQ-029 Inputs changing after acceptance do not affect the frame in progress.
REQ-030 tick_div=0 is legal and gives one tick per clock.

Reset
REQ-031 While reset_tx=1: data_pulse=1, busy=0, frame_ready=0, frame_done=0, crc_out=0, FSM=IDLE, and all counters=0.
REQ-032 frame_ready rises on the first clock after reset_tx deasserts.
REQ-033 Reset asserted mid-frame aborts the frame, drives data_pulse high on the next edge, and emits no TERM pulse.

Verification
REQ-034 tick_div=2, status_nb=0, data_fast=0, nibble_count=6, pause_en=0, single frame -> crc_out=5; sync high-to-low spacing 168 clocks; each nibble 36 clocks with a 15-clock low phase; frame_done once; TERM low pulse; busy falls 15 clocks after the TERM falling edge.
REQ-035 tick_div=0, data_fast=24'hFFFFFF, nibble_count=6 -> each data pulse is 27 clocks; crc_out matches the T-table model.
REQ-036 pause_en=1, pause_ticks=100, frame_valid held high -> frames are back-to-back; the falling-edge interval from CRC start to the next SYNC equals (12+crc)+100 ticks; no TERM.
REQ-037 nibble_count=3 and nibble_count=0 -> exactly 3 and 6 data pulses respectively; CRC is computed over the sent nibbles only.
REQ-038 reset_tx asserted during DATA -> data_pulse=1 and busy=0 the next clock; the next frame starts cleanly.
REQ-039 pause_ticks=5 -> the pause pulse is 12 ticks long.
